// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Op encodings, FSM states and the fixed iteration count live here.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } md_state_e;

    localparam int MD_ITERS = 32;
    localparam int MD_CNT_W = $clog2(MD_ITERS);

    // Bit 1 of the encoding separates divides from multiplies, bit 0 marks unsigned.
    function automatic logic op_is_div(input md_op_e op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input md_op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the control datapath and the muldiv unit.
// The master drives operands and move requests; the slave returns HI/LO and status.
interface muldiv_if #(
    parameter int WIDTH = 32
) ();

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, op, a, b, mthi, mtlo, wdata,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo, wdata,
        output hi, lo, busy, done
    );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU over a fixed 34-cycle sequence, plus MTHI/MTLO.
// Operands are reduced to magnitudes on start; signs are reapplied in FIX.
//
//   state | meaning
//   IDLE  | accept start (priority) or MTHI/MTLO writes
//   RUN   | one shift-add or restoring-divide step per cycle, 32 steps
//   FIX   | sign-correct the accumulator and write HI/LO, pulse done
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      reset,
    muldiv_if.slave   bus
);

    localparam int W2 = 2 * WIDTH;
    localparam logic [MD_CNT_W-1:0] CNT_LAST = MD_CNT_W'(MD_ITERS - 1);

    md_state_e           state_q,    state_d;
    logic [MD_CNT_W-1:0] cnt_q,      cnt_d;
    logic [W2-1:0]       acc_q,      acc_d;
    logic [WIDTH-1:0]    opnd_q,     opnd_d;
    logic [WIDTH-1:0]    a_raw_q,    a_raw_d;
    logic                is_div_q,   is_div_d;
    logic                neg_res_q,  neg_res_d;
    logic                neg_rem_q,  neg_rem_d;
    logic                div_zero_q, div_zero_d;
    logic [WIDTH-1:0]    hi_q,       hi_d;
    logic [WIDTH-1:0]    lo_q,       lo_d;
    logic                busy_q,     busy_d;
    logic                done_q,     done_d;

    md_op_e           op_in;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_rem;
    logic [WIDTH+1:0] div_diff;
    logic [W2-1:0]    acc_step;
    logic [W2-1:0]    prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    always_comb begin
        op_in = md_op_e'(bus.op);
        a_neg = op_is_signed(op_in) & bus.a[WIDTH-1];
        b_neg = op_is_signed(op_in) & bus.b[WIDTH-1];
        a_mag = a_neg ? -bus.a : bus.a;
        b_mag = b_neg ? -bus.b : bus.b;

        // Multiply: low half holds the multiplier, consumed LSB-first as the sum shifts in.
        mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, opnd_q};
        // Divide: shifted partial remainder can reach WIDTH+1 bits before the trial subtract.
        div_rem  = acc_q[W2-1:WIDTH-1];
        div_diff = {1'b0, div_rem} - {2'b00, opnd_q};

        if (is_div_q) begin
            if (!div_diff[WIDTH+1]) begin
                acc_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end else if (acc_q[0]) begin
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        end else begin
            acc_step = {1'b0, acc_q[W2-1:1]};
        end

        prod_fix = neg_res_q ? -acc_q : acc_q;
        quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = neg_rem_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        a_raw_d    = a_raw_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = RUN;
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                    acc_d      = {{WIDTH{1'b0}}, a_mag};
                    opnd_d     = b_mag;
                    a_raw_d    = bus.a;
                    is_div_d   = op_is_div(op_in);
                    neg_res_d  = a_neg ^ b_neg;
                    neg_rem_d  = a_neg & op_is_div(op_in);
                    div_zero_d = (bus.b == '0);
                end else begin
                    if (bus.mthi) hi_d = bus.wdata;
                    if (bus.mtlo) lo_d = bus.wdata;
                end
            end
            RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = FIX;
            end
            FIX: begin
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (div_zero_q) begin
                    hi_d = a_raw_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            a_raw_q    <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            a_raw_q    <= a_raw_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: expected {hi,lo} pairs are queued at start
// and popped when done pulses; timing and hazard behaviour checked inline.
module tb_muldiv_unit;

    logic clk;
    logic reset;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: begin
                q = sa * sb;
                p = q;
                return p;
            end
            2'b01: begin
                p = {32'b0, a} * {32'b0, b};
                return p;
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                if (op == 2'b10) begin
                    q = sa / sb;
                    r = sa % sb;
                end else begin
                    q = longint'({32'b0, a}) / longint'({32'b0, b});
                    r = longint'({32'b0, a}) % longint'({32'b0, b});
                end
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Called at a negedge; drives start for one cycle and returns at the negedge where done is high.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input bit poke, input string tag);
        logic [63:0] prev;
        logic [63:0] got;
        int busy_cnt;
        int guard;
        prev = {bus.hi, bus.lo};
        exp_q.push_back(exp);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = ~op;
        bus.a     = ~a;
        bus.b     = ~b;
        chk({tag, "_done_low_at_start"}, {63'b0, bus.done}, 64'd0);
        busy_cnt = 0;
        guard    = 0;
        while (bus.done !== 1'b1 && guard < 60) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (guard == 15) chk({tag, "_hilo_hold_in_run"}, {bus.hi, bus.lo}, prev);
            if (poke && guard == 10) begin
                bus.start = 1'b1;
                bus.mthi  = 1'b1;
                bus.mtlo  = 1'b1;
                bus.wdata = 32'hDEADBEEF;
            end
            if (poke && guard == 11) begin
                bus.start = 1'b0;
                bus.mthi  = 1'b0;
                bus.mtlo  = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        if (guard >= 60) begin
            checks++;
            errors++;
            $error("FAIL %s_timeout: observed no done expected done within 60 cycles", tag);
            void'(exp_q.pop_front());
        end else begin
            chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
            chk({tag, "_busy_low_at_done"}, {63'b0, bus.busy}, 64'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL %s_scoreboard: observed done expected no pending result", tag);
            end else begin
                got = {bus.hi, bus.lo};
                chk({tag, "_result"}, got, exp_q.pop_front());
            end
        end
    endtask

    task automatic do_move(input logic hi_en, input logic lo_en, input logic [31:0] data);
        bus.mthi  = hi_en;
        bus.mtlo  = lo_en;
        bus.wdata = data;
        @(negedge clk);
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        bit          done_seen;

        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.wdata = '0;
        reset     = 1'b0;
        #1 reset  = 1'b1;
        #2;
        chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        chk("reset_status", {62'b0, bus.busy, bus.done}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        do_move(1'b0, 1'b1, 32'h0000ABCD);
        chk("mtlo_write", {32'b0, bus.lo}, 64'h0000ABCD);
        do_move(1'b1, 1'b0, 32'h00001234);
        chk("mthi_write", {bus.hi, bus.lo}, 64'h00001234_0000ABCD);
        chk("move_no_done", {62'b0, bus.busy, bus.done}, 64'd0);

        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0, "multu_max");
        @(negedge clk);
        chk("done_one_cycle", {62'b0, bus.busy, bus.done}, 64'd0);
        run_op(2'b00, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB, 1'b0, "mult_neg");
        @(negedge clk);
        run_op(2'b10, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 1'b0, "div_neg7_2");
        @(negedge clk);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, "div_ovf");
        @(negedge clk);
        run_op(2'b11, 32'h00000064, 32'h00000000, 64'h00000064_FFFFFFFF, 1'b0, "divu_zero");
        @(negedge clk);
        run_op(2'b10, 32'hFFFFFF9C, 32'h00000000, 64'hFFFFFF9C_FFFFFFFF, 1'b0, "div_zero_neg");
        @(negedge clk);
        run_op(2'b01, 32'd3, 32'd4, 64'h00000000_0000000C, 1'b1, "busy_ignore");
        run_op(2'b11, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, "back_to_back");
        run_op(2'b10, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0, "div_7_neg2");
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i == 4) ? 32'($urandom_range(1, 20)) : $urandom;
            run_op(ro, ra, rb, model(ro, ra, rb), 1'b0, $sformatf("rand%0d", i));
            @(negedge clk);
        end

        bus.mthi  = 1'b1;
        bus.mtlo  = 1'b1;
        bus.wdata = 32'h5;
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.a     = 32'd9;
        bus.b     = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        chk("start_beats_move_busy", {63'b0, bus.busy}, 64'd1);
        done_seen = 1'b0;
        for (int i = 0; i < 40 && !done_seen; i++) begin
            @(negedge clk);
            done_seen = bus.done;
        end
        chk("start_beats_move_result", {bus.hi, bus.lo}, 64'h00000000_00000051);
        @(negedge clk);

        do_move(1'b1, 1'b0, 32'd5);
        do_move(1'b0, 1'b1, 32'd6);
        chk("hazard_pre_hilo", {bus.hi, bus.lo}, 64'h00000005_00000006);
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.a     = 32'd3;
        bus.b     = 32'd4;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midop_reset_hilo", {bus.hi, bus.lo}, 64'd0);
        chk("midop_reset_status", {62'b0, bus.busy, bus.done}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen = 1'b1;
        end
        chk("midop_reset_no_done", {63'b0, done_seen}, 64'd0);
        chk("midop_reset_hilo_after", {bus.hi, bus.lo}, 64'd0);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
